neural_simd_unpack: RTL and testbench
=====================================

// Module: neural_simd_unpack
// PURPOSE
//  Output-side unpacker for the 4-lane neural SIMD datapath. Accepts packed result
//  words (LANES x PIX_W-bit pixels per word) on a valid/ready interface and emits
//  them as a serial pixel stream, one pixel per cycle, lane 0 first.
//  Buffers up to DEPTH words so the packed producer does not stall while the
//  downstream pixel consumer drains. Supports per-lane keep mask and frame-last
//  marking. Provides a per-frame emitted-pixel count.
// PARAMETERS
//  LANES   4    pixels per packed word
//  PIX_W   8    bits per pixel
//  DEPTH   2    word-buffer entries; power of 2, >= 2
//  CNT_W   16   width of pix_count
// PORTS
//  clk          in   1            clock; all state on rising edge
//  rst_n        in   1            asynchronous active-low reset
//  clr          in   1            synchronous clear: empties buffer, zeroes lane ptr and count
//  in_valid     in   1            packed word present
//  in_ready     out  1            buffer can accept a word
//  in_word      in   LANES*PIX_W  packed pixels; lane k = in_word[k*PIX_W +: PIX_W]
//  in_keep      in   LANES        lane k emitted only if in_keep[k]=1
//  in_last      in   1            word is the final word of a frame
//  out_valid    out  1            out_pixel valid
//  out_ready    in   1            consumer accepts pixel
//  out_pixel    out  PIX_W        current pixel
//  out_last     out  1            final pixel of frame (with out_valid)
//  pix_count    out  CNT_W        pixels emitted in current frame
//  err_droplast out  1            sticky: a last word had in_keep == 0
// BEHAVIOUR
//  - Reset (async) / clr (sync, highest priority): buffer empty, wr/rd ptrs 0, lane ptr 0,
//    in_ready=1, out_valid=0, out_pixel=0, out_last=0, pix_count=0, err_droplast=0.
//  - Input: word accepted when in_valid && in_ready; in_ready = !full, no pass-through
//    (when full, a same-cycle pop does not allow a same-cycle push).
//  - Latency: word accepted in cycle N -> its first kept pixel has out_valid in cycle N+1.
//    out_* depend only on registered state; no combinational path from in_* to out_*.
//  - Lane pointer: points at lowest kept lane of head word not yet emitted.
//    out_pixel = head lane selected by pointer; transfer when out_valid && out_ready.
//    After a transfer, pointer advances to the next kept lane; if none remains, head word
//    is popped and pointer moves to lowest kept lane of the next entry. Throughput: 1 pixel/cycle
//    sustained, including back-to-back words (pop and next-head select happen in the same cycle).
//  - Words with in_keep == 0 are accepted and discarded, producing no output; discard
//    takes one cycle at the buffer head. If such a word has in_last=1, err_droplast sets.
//  - out_last = 1 on the highest kept lane of a word with in_last=1.
//  - pix_count: +1 per output transfer, saturates at all-ones; after the out_last transfer
//    it reads 0 on the next cycle (frame restart). Counter wraps never.
//  - out_valid held with stable out_pixel/out_last while out_ready=0.
//  - Pointer wrap: wr/rd ptrs modulo DEPTH with extra bit for full/empty distinction.
//  - Reset mid-frame: all buffered pixels discarded, no partial output afterwards.
// TESTING
//  1. Reset, push 0x44332211 keep=1111 last=1, out_ready=1 -> pixels 11,22,33,44 in cycles
//     N+1..N+4, out_last only with 44, pix_count 0 after.
//  2. Push keep=0101 word 0xDDCCBBAA -> emits AA then CC only; keep=0000 word -> no output.
//  3. out_ready=0, push 3 words (DEPTH=2) -> in_ready low after 2 accepted; third held until
//     first word fully drained; no pixel lost or duplicated.
//  4. Back-to-back 8 words keep=1111, out_ready=1 -> 32 pixels in 32 consecutive cycles.
//  5. keep=0000 with last=1 -> err_droplast=1 and stays until clr/reset.
//  6. Assert rst_n low after 2 pixels of a 4-pixel word -> out_valid=0 at once; no further output.

Source files
------------

// File: rtl/neural_simd_unpack_if.sv
// Handshake bundle for neural_simd_unpack.
//  in_*      : packed-word producer side (valid/ready, word, keep mask, frame last)
//  out_*     : serial pixel consumer side (valid/ready, pixel, frame last)
//  pix_count : pixels emitted in the current frame
//  err_droplast : sticky flag, a frame-last word carried no kept lanes
// master = producer/consumer environment, slave = the unpacker.
interface neural_simd_unpack_if #(
  parameter int LANES = 4,
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*PIX_W-1:0] in_word;
  logic [LANES-1:0]       in_keep;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [PIX_W-1:0]       out_pixel;
  logic                   out_last;
  logic [CNT_W-1:0]       pix_count;
  logic                   err_droplast;

  modport master (
    output in_valid, in_word, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_pixel, out_last, pix_count, err_droplast
  );

  modport slave (
    input  in_valid, in_word, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_pixel, out_last, pix_count, err_droplast
  );
endinterface

// File: rtl/neural_simd_unpack.sv
// Output-side unpacker: buffers up to DEPTH packed words and serialises them
// one pixel per cycle, lane 0 first, skipping lanes whose keep bit is clear.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  clr        : synchronous clear (buffer, lane state, count, error flag)
//  bus        : neural_simd_unpack_if slave (input words, output pixels,
//               pix_count, err_droplast)
module neural_simd_unpack #(
  parameter int LANES = 4,
  parameter int PIX_W = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  neural_simd_unpack_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = LANES * PIX_W;

  // Each entry keeps a "remaining lanes" mask: bits are cleared as lanes are
  // emitted, so the lowest set bit is always the lane pointer of that entry.
  logic [DEPTH-1:0][WW-1:0]    r_data;
  logic [DEPTH-1:0][LANES-1:0] r_mask;
  logic [DEPTH-1:0]            r_last;
  logic [PW-1:0]               r_wr, r_rd;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_err;

  logic [AW-1:0]    w_wr_idx, w_rd_idx;
  logic             w_empty, w_full, w_push, w_pop, w_xfer;
  logic             w_valid, w_last;
  logic [LANES-1:0] w_head, w_low, w_rest;
  logic [PIX_W-1:0] w_pix;

  assign w_wr_idx = r_wr[AW-1:0];
  assign w_rd_idx = r_rd[AW-1:0];
  assign w_empty  = (r_wr == r_rd);
  assign w_full   = (r_wr[PW-1] != r_rd[PW-1]) && (w_wr_idx == w_rd_idx);
  assign w_head   = w_empty ? '0 : r_mask[w_rd_idx];
  assign w_low    = w_head & (~w_head + LANES'(1));   // isolate lowest kept lane
  assign w_rest   = w_head & ~w_low;

  always_comb begin
    w_pix = '0;
    for (int k = 0; k < LANES; k++)
      if (w_low[k]) w_pix = r_data[w_rd_idx][k*PIX_W +: PIX_W];
  end

  assign w_valid = |w_head;
  assign w_last  = w_valid && r_last[w_rd_idx] && !(|w_rest);
  assign w_xfer  = w_valid && bus.out_ready;
  assign w_push  = bus.in_valid && !w_full;
  // Pop either an all-discard head (one cycle at head) or a head whose final
  // kept lane transfers now, so the next entry heads the buffer next cycle.
  assign w_pop   = (!w_empty && !w_valid) || (w_xfer && !(|w_rest));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_mask <= '0;
      r_last <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (clr) begin
      r_data <= '0;
      r_mask <= '0;
      r_last <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      // Push and head update never alias: a non-full, non-empty buffer has
      // distinct write and read slots, and an empty one has no transfer.
      if (w_push) begin
        r_data[w_wr_idx] <= bus.in_word;
        r_mask[w_wr_idx] <= bus.in_keep;
        r_last[w_wr_idx] <= bus.in_last;
        r_wr             <= r_wr + PW'(1);
        if (bus.in_last && !(|bus.in_keep)) r_err <= 1'b1;
      end
      if (w_xfer) r_mask[w_rd_idx] <= w_rest;
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_xfer) begin
        if (w_last)      r_cnt <= '0;
        else if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready     = !w_full;
  assign bus.out_valid    = w_valid;
  assign bus.out_pixel    = w_valid ? w_pix : '0;
  assign bus.out_last     = w_last;
  assign bus.pix_count    = r_cnt;
  assign bus.err_droplast = r_err;
endmodule

// File: tb/tb_neural_simd_unpack.sv
// Directed bench for neural_simd_unpack: drive on the falling edge, sample
// on the falling edge (state after the preceding rising edge).
module tb_neural_simd_unpack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  neural_simd_unpack_if #(.LANES(4), .PIX_W(8), .CNT_W(16)) bus ();

  neural_simd_unpack #(.LANES(4), .PIX_W(8), .DEPTH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  // word stimulus table and observed output stream
  logic [31:0] tw [16];
  logic [3:0]  tk [16];
  logic        tl [16];
  int          acc_cyc [16];
  logic [7:0]  qp [$];
  logic        ql [$];
  logic [15:0] qc [$];
  int          qcyc [$];
  int          blocked, stable_bad;

  // Streams tw/tk/tl[0..n-1]; out_ready low for the first 'stall' cycles.
  task automatic run_stream(input int n, input int stall, input int maxc);
    int idx = 0, cyc = 0, lastacc = 0;
    logic prev_st = 1'b0;
    logic [7:0] prev_pix = '0;
    qp.delete(); ql.delete(); qc.delete(); qcyc.delete();
    blocked = 0; stable_bad = 0;
    while (cyc < maxc) begin
      @(negedge clk);
      bus.out_ready = (cyc >= stall);
      if (bus.out_valid && !bus.out_ready) begin
        if (prev_st && bus.out_pixel !== prev_pix) stable_bad++;
        prev_st = 1'b1; prev_pix = bus.out_pixel;
      end else prev_st = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        qp.push_back(bus.out_pixel); ql.push_back(bus.out_last);
        qc.push_back(bus.pix_count); qcyc.push_back(cyc);
      end
      if (idx < n) begin
        bus.in_valid = 1'b1; bus.in_word = tw[idx];
        bus.in_keep = tk[idx]; bus.in_last = tl[idx];
        if (!bus.in_ready) blocked++;
        else begin acc_cyc[idx] = cyc; lastacc = cyc; idx++; end
      end else bus.in_valid = 1'b0;
      cyc++;
      if (idx == n && cyc - lastacc > 4 && !bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (cyc >= maxc) begin
      errors++;
      $display("FAIL stream_timeout: got %0d cycles, need < %0d", cyc, maxc);
    end
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_word = '0; bus.in_keep = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_pixel, bus.out_last, bus.pix_count, bus.err_droplast}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b px=%h l=%b cnt=%0d err=%b, need 1 0 00 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_pixel, bus.out_last, bus.pix_count, bus.err_droplast);
    end
  endtask

  task automatic test_basic();
    logic [7:0] ep [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    tw[0] = 32'h44332211; tk[0] = 4'b1111; tl[0] = 1'b1;
    run_stream(1, 0, 50);
    checks++;
    if (qp.size() !== 4) begin
      errors++; $display("FAIL basic_count: got %0d, need 4", qp.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({qp[i], ql[i], qc[i]} !== {ep[i], (i == 3), 16'(i)}) begin
          errors++;
          $display("FAIL basic_pix%0d: got %h last=%b cnt=%0d, need %h last=%b cnt=%0d",
                   i, qp[i], ql[i], qc[i], ep[i], (i == 3), i);
        end
      end
      checks++;
      if (qcyc[0] !== acc_cyc[0] + 1 || qcyc[3] !== acc_cyc[0] + 4) begin
        errors++;
        $display("FAIL basic_latency: got first %0d last %0d, need %0d %0d",
                 qcyc[0], qcyc[3], acc_cyc[0] + 1, acc_cyc[0] + 4);
      end
    end
    checks++;
    if (bus.pix_count !== 16'd0) begin
      errors++; $display("FAIL basic_count_restart: got %0d, need 0", bus.pix_count);
    end
  endtask

  task automatic test_keep();
    tw[0] = 32'hDDCCBBAA; tk[0] = 4'b0101; tl[0] = 1'b0;
    tw[1] = 32'h12345678; tk[1] = 4'b0000; tl[1] = 1'b0;
    run_stream(2, 0, 50);
    checks++;
    if (qp.size() !== 2 || qp[0] !== 8'hAA || qp[1] !== 8'hCC || ql[0] || ql[1]) begin
      errors++;
      $display("FAIL keep_mask: got %0d pixels first=%h second=%h, need 2 pixels AA CC, no last",
               qp.size(), (qp.size() > 0) ? qp[0] : 8'h0, (qp.size() > 1) ? qp[1] : 8'h0);
    end
    checks++;
    if (bus.pix_count !== 16'd2 || bus.err_droplast !== 1'b0) begin
      errors++;
      $display("FAIL keep_count: got cnt=%0d err=%b, need 2 0", bus.pix_count, bus.err_droplast);
    end
    do_clr();
    checks++;
    if (bus.pix_count !== 16'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_state: got cnt=%0d v=%b, need 0 0", bus.pix_count, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    tw[0] = 32'h04030201; tk[0] = 4'hF; tl[0] = 1'b0;
    tw[1] = 32'h08070605; tk[1] = 4'hF; tl[1] = 1'b0;
    tw[2] = 32'h0C0B0A09; tk[2] = 4'hF; tl[2] = 1'b1;
    run_stream(3, 6, 80);
    checks++;
    if (acc_cyc[1] !== 1 || acc_cyc[2] !== 10 || blocked !== 8) begin
      errors++;
      $display("FAIL bp_ready: got acc1=%0d acc2=%0d blocked=%0d, need 1 10 8",
               acc_cyc[1], acc_cyc[2], blocked);
    end
    checks++;
    if (stable_bad !== 0) begin
      errors++; $display("FAIL bp_hold: got %0d pixel changes while stalled, need 0", stable_bad);
    end
    checks++;
    if (qp.size() !== 12) begin
      errors++; $display("FAIL bp_count: got %0d, need 12", qp.size());
    end else begin
      for (int i = 0; i < 12; i++)
        if (qp[i] !== 8'(i + 1) || ql[i] !== (i == 11)) bad++;
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL bp_order: got %0d wrong pixels, need 0", bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int j = 0; j < 8; j++) begin
      tw[j] = {8'(j*4+4), 8'(j*4+3), 8'(j*4+2), 8'(j*4+1)};
      tk[j] = 4'hF; tl[j] = (j == 7);
    end
    run_stream(8, 0, 200);
    checks++;
    if (qp.size() !== 32) begin
      errors++; $display("FAIL b2b_count: got %0d, need 32", qp.size());
    end else begin
      for (int i = 0; i < 32; i++)
        if (qp[i] !== 8'(i + 1) || ql[i] !== (i == 31) || qcyc[i] !== qcyc[0] + i) bad++;
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL b2b_stream: got %0d bad beats, need 0", bad);
      end
      checks++;
      if (qcyc[0] !== acc_cyc[0] + 1) begin
        errors++; $display("FAIL b2b_latency: got %0d, need %0d", qcyc[0], acc_cyc[0] + 1);
      end
    end
  endtask

  task automatic test_droplast();
    tw[0] = 32'hFFFFFFFF; tk[0] = 4'b0000; tl[0] = 1'b1;
    run_stream(1, 0, 50);
    checks++;
    if (qp.size() !== 0 || bus.err_droplast !== 1'b1) begin
      errors++;
      $display("FAIL droplast_set: got %0d pixels err=%b, need 0 1", qp.size(), bus.err_droplast);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.err_droplast !== 1'b1) begin
      errors++; $display("FAIL droplast_sticky: got %b, need 1", bus.err_droplast);
    end
    do_clr();
    checks++;
    if (bus.err_droplast !== 1'b0) begin
      errors++; $display("FAIL droplast_clr: got %b, need 0", bus.err_droplast);
    end
  endtask

  task automatic test_midreset();
    int bad = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_word = 32'h44332211; bus.in_keep = 4'hF;
    bus.in_last = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pixel !== 8'h11) begin
      errors++; $display("FAIL mid_first: got v=%b %h, need 1 11", bus.out_valid, bus.out_pixel);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pixel !== 8'h00 || bus.pix_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b px=%h cnt=%0d, need 0 00 0",
               bus.out_valid, bus.out_pixel, bus.pix_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL mid_no_output: got %0d valid cycles, need 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_keep();
    test_backpressure();
    do_clr();
    test_back_to_back();
    test_droplast();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
